count_tick_gen: RTL and testbench

//  Upstream control stage for the up/down counter. Divides the system clock into a
//  one-cycle count-enable tick. Synchronises and debounces the raw direction switch.

---
 rtl/cnt_pkg.sv | 22 ++
 rtl/mode_debounce.sv | 105 ++++++++++
 rtl/count_tick_gen.sv | 111 +++++++++++
 tb/tb_count_tick_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared types and constants for the up/down counter control path.
// The mode encoding is also used by the counter itself.
package cnt_pkg;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_t;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned safe_clog2(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mode_debounce.sv
// Two-flop synchroniser followed by a STABLE/CHECK debounce FSM for the raw
// direction switch. A change is accepted after DEB_CYCLES consecutive differing samples.
module mode_debounce
  import cnt_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_in,
  output logic mode_db
);

  localparam int DW = safe_clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_mode_s;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_nxt;
  logic          w_accept;
  logic          r_mode_db;
  logic          w_mode_db_nxt;

  // Synchroniser resets to "up" so a held switch produces no spurious change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= MODE_UP;
      r_sync2 <= MODE_UP;
    end else begin
      r_sync1 <= mode_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mode_s = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DB_STABLE;
      r_dcnt    <= {DW{1'b0}};
      r_mode_db <= MODE_UP;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_mode_db <= w_mode_db_nxt;
    end
  end

  // The first differing sample already counts as one, hence dcnt starts at 1.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_accept    = 1'b0;
    case (r_state)
      DB_STABLE: begin
        if (w_mode_s != r_mode_db) begin
          if (DEB_CYCLES == 1) begin
            w_accept    = 1'b1;
            w_state_nxt = DB_STABLE;
            w_dcnt_nxt  = {DW{1'b0}};
          end else begin
            w_state_nxt = DB_CHECK;
            w_dcnt_nxt  = DW'(1);
          end
        end else begin
          w_state_nxt = DB_STABLE;
          w_dcnt_nxt  = {DW{1'b0}};
        end
      end
      DB_CHECK: begin
        if (w_mode_s == r_mode_db) begin
          w_state_nxt = DB_STABLE;
          w_dcnt_nxt  = {DW{1'b0}};
        end else if (r_dcnt == DCNT_LAST) begin
          w_accept    = 1'b1;
          w_state_nxt = DB_STABLE;
          w_dcnt_nxt  = {DW{1'b0}};
        end else begin
          w_state_nxt = DB_CHECK;
          w_dcnt_nxt  = r_dcnt + DW'(1);
        end
      end
      default: begin
        w_state_nxt = DB_STABLE;
        w_dcnt_nxt  = {DW{1'b0}};
      end
    endcase
  end

  always_comb begin
    w_mode_db_nxt = r_mode_db;
    if (w_accept) begin
      w_mode_db_nxt = w_mode_s;
    end else begin
      w_mode_db_nxt = r_mode_db;
    end
  end

  assign mode_db = r_mode_db;

endmodule

// File: rtl/count_tick_gen.sv
// Prescaler producing a one-cycle count-enable tick plus tick-aligned direction.
// Define CNT_CLKD_OUT_EN to add the divided square clock output clk_d.
module count_tick_gen
  import cnt_pkg::*;
#(
  parameter  int DIV        = 8,
  parameter  int DEB_CYCLES = 4,
  localparam int CW         = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode_in,
  output logic          tick,
  output logic          mode_out,
  output logic          dir_chg,
  output logic [CW-1:0] div_cnt
`ifdef CNT_CLKD_OUT_EN
  ,
  output logic          clk_d
`endif
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wrap;
  logic          r_tick;
  logic          r_mode_out;
  logic          w_mode_out_nxt;
  logic          r_dir_chg;
  logic          w_dir_chg_nxt;
  logic          w_mode_db;

  mode_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .mode_in(mode_in),
    .mode_db(w_mode_db)
  );

  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_div_cnt;
    if (en) begin
      if (r_div_cnt == CNT_LAST) begin
        w_wrap    = 1'b1;
        w_cnt_nxt = {CW{1'b0}};
      end else begin
        w_cnt_nxt = r_div_cnt + CW'(1);
      end
    end else begin
      w_cnt_nxt = r_div_cnt;
    end
  end

  // Uses the pre-edge debounced value, so an acceptance on the tick edge waits a period.
  always_comb begin
    w_mode_out_nxt = r_mode_out;
    w_dir_chg_nxt  = 1'b0;
    if (w_wrap) begin
      w_mode_out_nxt = w_mode_db;
      w_dir_chg_nxt  = (w_mode_db != r_mode_out);
    end else begin
      w_mode_out_nxt = r_mode_out;
      w_dir_chg_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt  <= {CW{1'b0}};
      r_tick     <= 1'b0;
      r_mode_out <= MODE_UP;
      r_dir_chg  <= 1'b0;
    end else begin
      r_div_cnt  <= w_cnt_nxt;
      r_tick     <= w_wrap;
      r_mode_out <= w_mode_out_nxt;
      r_dir_chg  <= w_dir_chg_nxt;
    end
  end

  assign div_cnt  = r_div_cnt;
  assign tick     = r_tick;
  assign mode_out = r_mode_out;
  assign dir_chg  = r_dir_chg;

`ifdef CNT_CLKD_OUT_EN
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic r_clk_d;

  // Tracks the next prescaler value so clk_d rises together with div_cnt returning to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_d <= 1'b0;
    end else if (en) begin
      r_clk_d <= (w_cnt_nxt < HALF);
    end else begin
      r_clk_d <= r_clk_d;
    end
  end

  assign clk_d = r_clk_d;
`endif

endmodule

// File: tb/tb_count_tick_gen.sv
// Self-checking bench for count_tick_gen (DIV=8, DEB_CYCLES=4) with a run-length reference model.
module tb_count_tick_gen;

  localparam int DIV = 8;
  localparam int DEB = 4;
  localparam int CW  = $clog2(DIV);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          mode_in = 1'b1;
  logic          tick;
  logic          mode_out;
  logic          dir_chg;
  logic [CW-1:0] div_cnt;
`ifdef CNT_CLKD_OUT_EN
  logic          clk_d;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase counter, two-deep input delay, run length of differing samples.
  int m_phase;
  int m_run;
  bit m_tick, m_mout, m_dchg, m_db, m_s1, m_s2, m_clkd;

  count_tick_gen #(.DIV(DIV), .DEB_CYCLES(DEB)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode_in (mode_in),
    .tick    (tick),
    .mode_out(mode_out),
    .dir_chg (dir_chg),
    .div_cnt (div_cnt)
`ifdef CNT_CLKD_OUT_EN
    ,
    .clk_d   (clk_d)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_run = 0;
    m_tick = 1'b0; m_mout = 1'b1; m_dchg = 1'b0; m_db = 1'b1;
    m_s1 = 1'b1; m_s2 = 1'b1; m_clkd = 1'b0;
  endtask

  // One active edge; inputs are stable across it and outputs are sampled 1 time unit later.
  task automatic cycle();
    bit e, mi, nt;
    e = en;
    mi = mode_in;
    @(posedge clk);
    nt = e && (m_phase == DIV - 1);
    if (nt) begin
      m_dchg = (m_db != m_mout);
      m_mout = m_db;
    end else begin
      m_dchg = 1'b0;
    end
    m_tick = nt;
    if (e) m_phase = (m_phase + 1) % DIV;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = mi;
    if (e) m_clkd = (m_phase < DIV / 2);
    #1;
  endtask

  function automatic logic [CW+2:0] exp_vec();
    return {m_tick, m_mout, m_dchg, CW'(m_phase)};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({tick, mode_out, dir_chg, div_cnt} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_async got=%b exp=%b", {tick, mode_out, dir_chg, div_cnt}, {1'b0, 1'b1, 1'b0, 3'd0});
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({tick, mode_out, dir_chg, div_cnt} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_held got=%b exp=%b", {tick, mode_out, dir_chg, div_cnt}, {1'b0, 1'b1, 1'b0, 3'd0});
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_tick_period();
    en = 1'b1;
    mode_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      n_cmp++;
      if ({tick, mode_out, dir_chg, div_cnt} !== {(k % 8 == 0), 1'b1, 1'b0, CW'(k % 8)}) begin
        n_err++;
        $display("FAIL tick_period edge=%0d got=%b exp=%b", k, {tick, mode_out, dir_chg, div_cnt},
                 {(k % 8 == 0), 1'b1, 1'b0, CW'(k % 8)});
      end
`ifdef CNT_CLKD_OUT_EN
      n_cmp++;
      if (clk_d !== ((k % 8) < 4)) begin
        n_err++;
        $display("FAIL clk_d edge=%0d got=%b exp=%b", k, clk_d, ((k % 8) < 4));
      end
`endif
    end
  endtask

  task automatic test_glitch();
    mode_in = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 4) mode_in = 1'b1;
      cycle();
      n_cmp++;
      if ({u_dut.u_deb.mode_db, mode_out, dir_chg} !== 3'b110 || {tick, mode_out, dir_chg, div_cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch edge=%0d db=%b got=%b exp=%b", k, u_dut.u_deb.mode_db,
                 {tick, mode_out, dir_chg, div_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_mode_change();
    int pulses;
    pulses = 0;
    mode_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (k == 5 || k == 6) begin
        n_cmp++;
        if (u_dut.u_deb.mode_db !== (k == 5)) begin
          n_err++;
          $display("FAIL deb_latency edge=%0d got=%b exp=%b", k, u_dut.u_deb.mode_db, (k == 5));
        end
      end
      if (dir_chg === 1'b1) pulses++;
      n_cmp++;
      if ({tick, mode_out, dir_chg, div_cnt} !== exp_vec() || (dir_chg && !tick)) begin
        n_err++;
        $display("FAIL mode_change edge=%0d got=%b exp=%b", k, {tick, mode_out, dir_chg, div_cnt}, exp_vec());
      end
    end
    n_cmp++;
    if (pulses != 1 || mode_out !== 1'b0) begin
      n_err++;
      $display("FAIL dir_chg_count got=%0d/%b exp=1/0", pulses, mode_out);
    end
  endtask

  task automatic test_en_pause();
    int k;
    k = 0;
    while (div_cnt !== CW'(3) && k < 16) begin
      cycle();
      k++;
    end
    n_cmp++;
    if (div_cnt !== CW'(3)) begin
      n_err++;
      $display("FAIL pause_wait timeout got=%0d exp=3", div_cnt);
    end
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      n_cmp++;
      if ({tick, div_cnt} !== {1'b0, CW'(3)} || {tick, mode_out, dir_chg, div_cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL pause_hold cyc=%0d got=%b exp=%b", j, {tick, mode_out, dir_chg, div_cnt}, exp_vec());
      end
    end
    en = 1'b1;
    k = 0;
    do begin
      cycle();
      k++;
    end while (tick !== 1'b1 && k < 16);
    n_cmp++;
    if (k != 5) begin
      n_err++;
      $display("FAIL resume_tick got=%0d edges exp=5", k);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (div_cnt !== CW'(0) && k < 16) begin
      cycle();
      k++;
    end
    mode_in = ~mode_out;
    repeat (6) cycle();
    n_cmp++;
    if ({div_cnt, u_dut.u_deb.mode_db} !== {CW'(6), ~mode_out}) begin
      n_err++;
      $display("FAIL pending_setup got=%b exp=%b", {div_cnt, u_dut.u_deb.mode_db}, {CW'(6), ~mode_out});
    end
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({tick, mode_out, dir_chg, div_cnt} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid got=%b exp=%b", {tick, mode_out, dir_chg, div_cnt}, {1'b0, 1'b1, 1'b0, 3'd0});
    end
    mode_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      cycle();
      n_cmp++;
      if ({tick, mode_out, dir_chg, div_cnt} !== {(j == 8), 1'b1, 1'b0, CW'(j % 8)}) begin
        n_err++;
        $display("FAIL after_reset edge=%0d got=%b exp=%b", j, {tick, mode_out, dir_chg, div_cnt},
                 {(j == 8), 1'b1, 1'b0, CW'(j % 8)});
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) mode_in = ~mode_in;
      en = ($urandom_range(0, 7) != 0);
      cycle();
      n_cmp++;
      if ({tick, mode_out, dir_chg, div_cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", k, {tick, mode_out, dir_chg, div_cnt}, exp_vec());
      end
`ifdef CNT_CLKD_OUT_EN
      n_cmp++;
      if (clk_d !== m_clkd) begin
        n_err++;
        $display("FAIL random_clk_d cyc=%0d got=%b exp=%b", k, clk_d, m_clkd);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tick_period();
    test_glitch();
    test_mode_change();
    test_en_pause();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
